bb_phase_detector_voter: RTL and testbench
==========================================

Name: bb_phase_detector_voter

Overview:
- Bang-bang (Alexander) phase detector with majority-vote decimation. It is the producer of the Up/Dn pulses consumed by the CDR digital loop filter.
- Each clk it takes one data-centre sample and one edge sample. It classifies each bit boundary as early, late or no-transition, and accumulates a signed vote over a fixed window.
- At the end of each window it issues at most one Up or Dn pulse.
- It also runs a lock detector and a no-transition flag for link bring-up monitoring.

Parameters:
- VOTE_LEN, 8: samples per vote window; must be a power of 2 and ≥2.
- THRESH, 2: minimum |net vote| that produces an Up/Dn pulse.
- MIN_TRANS, 2: minimum transitions per window for the window to count as quiet.
- LOCK_WINDOWS, 4: consecutive quiet windows required to assert lock.
- UNLOCK_WINDOWS, 2: consecutive non-quiet windows required to drop lock.

Ports:
- clk  in  1  recovered/sampling clock, one UI per cycle
- rst  in  1  asynchronous active-high reset
- en  in  1  sample-valid / detector enable
- data_smp  in  1  data sample at the centre of bit n
- edge_smp  in  1  edge sample between bit n-1 and bit n
- Up  out  1  one-cycle pulse: clock is late, advance phase
- Dn  out  1  one-cycle pulse: clock is early, retard phase
- net_vote  out  $clog2(VOTE_LEN)+2  signed net vote of the last completed window
- no_trans  out  1  last completed window had zero transitions
- lock  out  1  lock indicator

Behaviour:
- Reset (async, rst=1): all outputs are 0.
  - Internal state cleared: window counter = 0, accumulator = 0, transition count = 0, prev_valid = 0, lock FSM = UNLOCKED, lock counters = 0.
- Classification per enabled cycle:
  - A = previous data_smp, T = edge_smp, B = data_smp.
  - If prev_valid = 0, or A = B: contributes 0 and is not a transition.
  - If A≠B and T=B: late, contributes +1, counts as a transition.
  - If A≠B and T=A: early, contributes -1, counts as a transition.
- prev data register and prev_valid update only when en=1.
- en=0:
  - Window counter, accumulator and transition count hold.
  - Up = Dn = 0.
  - prev_valid is cleared, so the first sample after re-enable contributes 0.
- Window: the counter runs 0..VOTE_LEN-1 on enabled cycles and wraps to 0 after VOTE_LEN-1.
- At the enabled cycle where the counter = VOTE_LEN-1, let sum = accumulator + this cycle's contribution. Registered at that posedge:
  - Up = (sum ≥ THRESH).
  - Dn = (sum ≤ -THRESH).
  - net_vote = sum.
  - no_trans = (total transitions == 0).
  - Accumulator and transition count reset to 0.
- Up and Dn are never both 1. Each is high for exactly one cycle, then 0 on the next posedge.
- Latency: the decision is visible immediately after the posedge that samples the last element of the window.
- Accumulator width is $clog2(VOTE_LEN)+2 signed and cannot overflow, since |sum| ≤ VOTE_LEN.
- Lock FSM, evaluated at each window end. quiet = |sum| < THRESH AND transitions ≥ MIN_TRANS.
  - UNLOCKED: quiet → LOCKING with qcnt = 1; otherwise stay.
  - LOCKING: quiet → qcnt+1, and enter LOCKED when qcnt+1 = LOCK_WINDOWS; not quiet → UNLOCKED, qcnt = 0.
  - LOCKED: not quiet → ucnt+1, and go to UNLOCKED when ucnt+1 = UNLOCK_WINDOWS; quiet → ucnt = 0.
  - lock = (state == LOCKED), registered in the same cycle as the window-end outputs.
- Reset mid-window discards the partial window; the next window needs a full VOTE_LEN enabled samples.

Decomposition:
- Package cdr_pkg:
  - lock_state_e {UNLOCKED, LOCKING, LOCKED}.
  - pd_class_e {PD_NONE, PD_EARLY, PD_LATE}.
  - Vote-width helper constant.
- Sub-module cdr_lock_detector: the lock FSM plus qcnt/ucnt.
  - Inputs: clk, rst, win_end, quiet.
  - Output: lock.

Test Plan:
- Late-dominant pattern: data 0101…, edge_smp = data_smp, en=1, starting 8 cycles after reset.
  - Window 1 (first sample has prev_valid = 0): net_vote = +7, Up pulses at sample 8.
  - Later windows: net_vote = +8, Up pulses every 8th cycle, Dn stays 0.
- Early-dominant pattern: data 0101…, edge_smp = previous data.
  - Window 1: net_vote = -7. Later windows: net_vote = -8.
  - Dn pulses every 8 cycles, Up stays 0.
- Constant data = 1 for 16 cycles → Up = Dn = 0, net_vote = 0, no_trans = 1, lock = 0.
- Alternating data with late/early alternating per transition (net 0, 8 transitions per window) → no Up/Dn; lock rises at the end of the 4th quiet window.
- Lock hysteresis:
  - From lock=1, two all-late windows → lock = 0 at the 2nd window end.
  - From lock=1, one all-late window followed by a quiet window → lock stays 1.
- Interruptions:
  - rst after 5 late samples → all outputs 0. The next Up occurs only after 8 further enabled samples (the first of them contributes 0).
  - en=0 for 3 cycles mid-window → the window stretches by 3 cycles, and the counter resumes from its held value.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared types and helpers for the bang-bang phase detector and its lock monitor.
package cdr_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    typedef enum logic [1:0] {
        PD_NONE  = 2'd0,
        PD_EARLY = 2'd1,
        PD_LATE  = 2'd2
    } pd_class_e;

    // Signed vote width: |sum| <= vote_len, plus a sign bit and headroom.
    function automatic int vote_width(input int vote_len);
        return $clog2(vote_len) + 2;
    endfunction

    // Alexander classification of one bit boundary (a = previous bit, t = edge, b = current bit).
    function automatic pd_class_e pd_classify(input logic valid, input logic a,
                                              input logic t, input logic b);
        pd_class_e cls;
        if (!valid || (a == b)) begin
            cls = PD_NONE;
        end else if (t == b) begin
            cls = PD_LATE;
        end else begin
            cls = PD_EARLY;
        end
        return cls;
    endfunction

endpackage

// File: rtl/cdr_lock_detector.sv
// Window-rate lock FSM: enters lock after LOCK_WINDOWS consecutive quiet windows,
// drops it after UNLOCK_WINDOWS consecutive non-quiet windows.
module cdr_lock_detector
    import cdr_pkg::*;
#(
    parameter int LOCK_WINDOWS   = 4,
    parameter int UNLOCK_WINDOWS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic win_end,
    input  logic quiet,
    output logic lock
);

    localparam int QW = $clog2(LOCK_WINDOWS + 1);
    localparam int UW = $clog2(UNLOCK_WINDOWS + 1);

    lock_state_e   state_r, state_s;
    logic [QW-1:0] qcnt_r, qcnt_s, qcnt_inc_s;
    logic [UW-1:0] ucnt_r, ucnt_s, ucnt_inc_s;
    logic          lock_r;

    // Next-state and counter update, only evaluated at window boundaries.
    always_comb begin
        state_s    = state_r;
        qcnt_s     = qcnt_r;
        ucnt_s     = ucnt_r;
        qcnt_inc_s = qcnt_r + QW'(1);
        ucnt_inc_s = ucnt_r + UW'(1);
        if (win_end) begin
            case (state_r)
                UNLOCKED: begin
                    if (quiet) begin
                        qcnt_s = QW'(1);
                        state_s = (LOCK_WINDOWS <= 1) ? LOCKED : LOCKING;
                        ucnt_s = UW'(0);
                    end else begin
                        qcnt_s = QW'(0);
                    end
                end
                LOCKING: begin
                    if (!quiet) begin
                        state_s = UNLOCKED;
                        qcnt_s  = QW'(0);
                    end else if (qcnt_inc_s == QW'(LOCK_WINDOWS)) begin
                        state_s = LOCKED;
                        qcnt_s  = QW'(0);
                        ucnt_s  = UW'(0);
                    end else begin
                        qcnt_s = qcnt_inc_s;
                    end
                end
                LOCKED: begin
                    if (quiet) begin
                        ucnt_s = UW'(0);
                    end else if (ucnt_inc_s == UW'(UNLOCK_WINDOWS)) begin
                        state_s = UNLOCKED;
                        ucnt_s  = UW'(0);
                        qcnt_s  = QW'(0);
                    end else begin
                        ucnt_s = ucnt_inc_s;
                    end
                end
                default: begin
                    state_s = UNLOCKED;
                    qcnt_s  = QW'(0);
                    ucnt_s  = UW'(0);
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered lock flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= UNLOCKED;
            qcnt_r  <= QW'(0);
            ucnt_r  <= UW'(0);
            lock_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            qcnt_r  <= qcnt_s;
            ucnt_r  <= ucnt_s;
            lock_r  <= (state_s == LOCKED);
        end
    end

    assign lock = lock_r;

endmodule

// File: rtl/bb_phase_detector_voter.sv
// Alexander bang-bang phase detector with majority-vote decimation into
// single-cycle Up/Dn pulses, plus no-transition and lock monitoring.
module bb_phase_detector_voter
    import cdr_pkg::*;
#(
    parameter int VOTE_LEN       = 8,
    parameter int THRESH         = 2,
    parameter int MIN_TRANS      = 2,
    parameter int LOCK_WINDOWS   = 4,
    parameter int UNLOCK_WINDOWS = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic                                    data_smp,
    input  logic                                    edge_smp,
    output logic                                    Up,
    output logic                                    Dn,
    output logic signed [vote_width(VOTE_LEN)-1:0]  net_vote,
    output logic                                    no_trans,
    output logic                                    lock
);

    localparam int VW = vote_width(VOTE_LEN);
    localparam int CW = (VOTE_LEN > 1) ? $clog2(VOTE_LEN) : 1;
    localparam int TW = $clog2(VOTE_LEN) + 1;
    localparam logic signed [VW-1:0] THR_P = VW'(THRESH);
    localparam logic signed [VW-1:0] THR_N = VW'(-THRESH);

    logic [CW-1:0]          cnt_r;
    logic signed [VW-1:0]   acc_r;
    logic [TW-1:0]          trans_r;
    logic                   prev_data_r;
    logic                   prev_valid_r;
    logic                   up_r, dn_r, no_trans_r;
    logic signed [VW-1:0]   net_vote_r;

    pd_class_e              cls_s;
    logic signed [VW-1:0]   contrib_s;
    logic signed [VW-1:0]   sum_s;
    logic [TW-1:0]          trans_total_s;
    logic                   win_end_s;
    logic                   quiet_s;

    // Classify this boundary and form the window totals including it.
    always_comb begin
        cls_s = pd_classify(prev_valid_r, prev_data_r, edge_smp, data_smp);
        case (cls_s)
            PD_LATE:  contrib_s = VW'(1);
            PD_EARLY: contrib_s = VW'(-1);
            default:  contrib_s = VW'(0);
        endcase
        sum_s         = acc_r + contrib_s;
        trans_total_s = trans_r + ((cls_s != PD_NONE) ? TW'(1) : TW'(0));
        win_end_s     = en && (cnt_r == CW'(VOTE_LEN - 1));
        quiet_s       = (sum_s < THR_P) && (sum_s > THR_N) &&
                        (trans_total_s >= TW'(MIN_TRANS));
    end

    // Window counter, accumulator, transition count and previous-bit history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= CW'(0);
            acc_r        <= VW'(0);
            trans_r      <= TW'(0);
            prev_data_r  <= 1'b0;
            prev_valid_r <= 1'b0;
        end else if (en) begin
            prev_data_r  <= data_smp;
            prev_valid_r <= 1'b1;
            if (win_end_s) begin
                cnt_r   <= CW'(0);
                acc_r   <= VW'(0);
                trans_r <= TW'(0);
            end else begin
                cnt_r   <= cnt_r + CW'(1);
                acc_r   <= sum_s;
                trans_r <= trans_total_s;
            end
        end else begin
            prev_valid_r <= 1'b0;
        end
    end

    // Window-end decision outputs; Up/Dn fall back to 0 on every other cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_r       <= 1'b0;
            dn_r       <= 1'b0;
            net_vote_r <= VW'(0);
            no_trans_r <= 1'b0;
        end else if (win_end_s) begin
            up_r       <= (sum_s >= THR_P);
            dn_r       <= (sum_s <= THR_N);
            net_vote_r <= sum_s;
            no_trans_r <= (trans_total_s == TW'(0));
        end else begin
            up_r <= 1'b0;
            dn_r <= 1'b0;
        end
    end

    cdr_lock_detector #(
        .LOCK_WINDOWS   (LOCK_WINDOWS),
        .UNLOCK_WINDOWS (UNLOCK_WINDOWS)
    ) u_lock (
        .clk     (clk),
        .rst     (rst),
        .win_end (win_end_s),
        .quiet   (quiet_s),
        .lock    (lock)
    );

    assign Up       = up_r;
    assign Dn       = dn_r;
    assign net_vote = net_vote_r;
    assign no_trans = no_trans_r;

endmodule

// File: tb/tb_bb_phase_detector_voter.sv
// Scenario and randomized checks of bb_phase_detector_voter against a window-level reference model.
module tb_bb_phase_detector_voter;

    localparam int VOTE_LEN = 8, THRESH = 2, MIN_TRANS = 2, LOCK_WINDOWS = 4, UNLOCK_WINDOWS = 2;
    localparam int VW = 5;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0, data_smp = 1'b0, edge_smp = 1'b0;
    logic up, dn, no_trans, lock;
    logic signed [VW-1:0] net_vote;

    int n_vec = 0, n_err = 0;
    bit cur_d = 1'b0;

    // Reference model state
    bit m_prev, m_pv, m_up, m_dn, m_nt, m_locked;
    int m_n, m_sum, m_tr, m_net, m_qrun, m_urun;

    bb_phase_detector_voter #(
        .VOTE_LEN(VOTE_LEN), .THRESH(THRESH), .MIN_TRANS(MIN_TRANS),
        .LOCK_WINDOWS(LOCK_WINDOWS), .UNLOCK_WINDOWS(UNLOCK_WINDOWS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .data_smp(data_smp), .edge_smp(edge_smp),
        .Up(up), .Dn(dn), .net_vote(net_vote), .no_trans(no_trans), .lock(lock)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_vec();
        logic [4:0] nv;
        nv = 5'(m_net);
        return {m_up, m_dn, nv, m_nt, m_locked};
    endfunction

    task automatic model_reset();
        m_prev = 1'b0; m_pv = 1'b0; m_up = 1'b0; m_dn = 1'b0; m_nt = 1'b0; m_locked = 1'b0;
        m_n = 0; m_sum = 0; m_tr = 0; m_net = 0; m_qrun = 0; m_urun = 0;
    endtask

    // Drive one cycle and advance the model by the window rules; returns 1us-free, bounded by clock.
    task automatic step(input bit e, input bit d, input bit t);
        bit quiet;
        @(negedge clk);
        en = e; data_smp = d; edge_smp = t;
        @(posedge clk);
        m_up = 1'b0; m_dn = 1'b0;
        if (e) begin
            if (m_pv && (m_prev != d)) begin
                m_tr++;
                m_sum += (t == d) ? 1 : -1;
            end
            m_n++;
            m_prev = d; m_pv = 1'b1;
            if (m_n == VOTE_LEN) begin
                m_up = (m_sum >= THRESH);
                m_dn = (m_sum <= -THRESH);
                m_net = m_sum;
                m_nt = (m_tr == 0);
                quiet = (m_sum < THRESH) && (m_sum > -THRESH) && (m_tr >= MIN_TRANS);
                if (!m_locked) begin
                    m_qrun = quiet ? m_qrun + 1 : 0;
                    if (m_qrun == LOCK_WINDOWS) begin m_locked = 1'b1; m_urun = 0; end
                end else begin
                    m_urun = quiet ? 0 : m_urun + 1;
                    if (m_urun == UNLOCK_WINDOWS) begin m_locked = 1'b0; m_qrun = 0; end
                end
                m_sum = 0; m_tr = 0; m_n = 0;
            end
        end else begin
            m_pv = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({up, dn, net_vote, no_trans, lock} !== 9'd0) begin
            n_err++;
            $display("FAIL reset: got %b want %b", {up, dn, net_vote, no_trans, lock}, 9'd0);
        end
    endtask

    // Alternating data with edge equal to the new bit: every boundary is late.
    task automatic test_late();
        apply_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        cur_d = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, cur_d, cur_d);
            cur_d = ~cur_d;
            n_vec++;
            if ({up, dn, net_vote, no_trans, lock} !== exp_vec()) begin
                n_err++;
                $display("FAIL late cyc%0d: got %b want %b", i, {up, dn, net_vote, no_trans, lock}, exp_vec());
            end
            if (i == 7 || i == 15) begin
                n_vec++;
                if (up !== 1'b1 || dn !== 1'b0 || net_vote !== ((i == 7) ? 5'sd7 : 5'sd8)) begin
                    n_err++;
                    $display("FAIL late_window%0d: got up=%b dn=%b net=%0d want up=1 dn=0 net=%0d",
                             i / 8, up, dn, net_vote, (i == 7) ? 7 : 8);
                end
            end
        end
    endtask

    // Alternating data with edge equal to the old bit: every boundary is early.
    task automatic test_early();
        apply_reset();
        cur_d = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, cur_d, ~cur_d);
            cur_d = ~cur_d;
            n_vec++;
            if ({up, dn, net_vote, no_trans, lock} !== exp_vec()) begin
                n_err++;
                $display("FAIL early cyc%0d: got %b want %b", i, {up, dn, net_vote, no_trans, lock}, exp_vec());
            end
            if (i == 7 || i == 23) begin
                n_vec++;
                if (dn !== 1'b1 || up !== 1'b0 || net_vote !== ((i == 7) ? -5'sd7 : -5'sd8)) begin
                    n_err++;
                    $display("FAIL early_window%0d: got up=%b dn=%b net=%0d want up=0 dn=1 net=%0d",
                             i / 8, up, dn, net_vote, (i == 7) ? -7 : -8);
                end
            end
        end
    endtask

    task automatic test_constant();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b1);
            n_vec++;
            if ({up, dn, net_vote, no_trans, lock} !== exp_vec()) begin
                n_err++;
                $display("FAIL const cyc%0d: got %b want %b", i, {up, dn, net_vote, no_trans, lock}, exp_vec());
            end
        end
        n_vec++;
        if ({up, dn, net_vote, no_trans, lock} !== 9'b00_00000_1_0) begin
            n_err++;
            $display("FAIL const_final: got %b want %b", {up, dn, net_vote, no_trans, lock}, 9'b00_00000_1_0);
        end
    endtask

    // Runs nwin windows of transitions alternating late/early.
    task automatic run_quiet(input int nwin, input string tag);
        bit late_next = 1'b1;
        for (int i = 0; i < nwin * VOTE_LEN; i++) begin
            cur_d = ~cur_d;
            step(1'b1, cur_d, late_next ? cur_d : ~cur_d);
            late_next = ~late_next;
            n_vec++;
            if ({up, dn, net_vote, no_trans, lock} !== exp_vec()) begin
                n_err++;
                $display("FAIL %s cyc%0d: got %b want %b", tag, i, {up, dn, net_vote, no_trans, lock}, exp_vec());
            end
        end
    endtask

    task automatic run_late(input int nwin, input string tag);
        for (int i = 0; i < nwin * VOTE_LEN; i++) begin
            cur_d = ~cur_d;
            step(1'b1, cur_d, cur_d);
            n_vec++;
            if ({up, dn, net_vote, no_trans, lock} !== exp_vec()) begin
                n_err++;
                $display("FAIL %s cyc%0d: got %b want %b", tag, i, {up, dn, net_vote, no_trans, lock}, exp_vec());
            end
        end
    endtask

    task automatic test_quiet_lock();
        apply_reset();
        run_quiet(3, "quiet");
        n_vec++;
        if (lock !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b want 0", lock); end
        run_quiet(1, "quiet4");
        n_vec++;
        if (lock !== 1'b1 || up !== 1'b0 || dn !== 1'b0) begin
            n_err++;
            $display("FAIL lock_rise: got lock=%b up=%b dn=%b want lock=1 up=0 dn=0", lock, up, dn);
        end
    endtask

    task automatic test_hysteresis();
        run_late(1, "hyst_late1");
        n_vec++;
        if (lock !== 1'b1) begin n_err++; $display("FAIL hyst_one_bad: got %b want 1", lock); end
        run_late(1, "hyst_late2");
        n_vec++;
        if (lock !== 1'b0) begin n_err++; $display("FAIL hyst_drop: got %b want 0", lock); end
        run_quiet(4, "hyst_relock");
        run_late(1, "hyst_late3");
        run_quiet(1, "hyst_recover");
        n_vec++;
        if (lock !== 1'b1) begin n_err++; $display("FAIL hyst_hold: got %b want 1", lock); end
    endtask

    task automatic test_rst_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) begin cur_d = ~cur_d; step(1'b1, cur_d, cur_d); end
        apply_reset();
        n_vec++;
        if ({up, dn, net_vote, no_trans, lock} !== 9'd0) begin
            n_err++;
            $display("FAIL rst_mid_zero: got %b want %b", {up, dn, net_vote, no_trans, lock}, 9'd0);
        end
        for (int i = 0; i < 8; i++) begin
            cur_d = ~cur_d;
            step(1'b1, cur_d, cur_d);
            n_vec++;
            if (up !== ((i == 7) ? 1'b1 : 1'b0) || ((i == 7) && net_vote !== 5'sd7)) begin
                n_err++;
                $display("FAIL rst_mid s%0d: got up=%b net=%0d want up=%0d", i, up, net_vote, (i == 7) ? 1 : 0);
            end
        end
    endtask

    task automatic test_en_gap();
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            if (i >= 4 && i < 7) begin
                step(1'b0, cur_d, cur_d);
            end else begin
                cur_d = ~cur_d;
                step(1'b1, cur_d, cur_d);
            end
            n_vec++;
            if (up !== ((i == 10) ? 1'b1 : 1'b0) || ((i == 10) && net_vote !== 5'sd6)) begin
                n_err++;
                $display("FAIL en_gap c%0d: got up=%b net=%0d want up=%0d net=6", i, up, net_vote, (i == 10) ? 1 : 0);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom));
            n_vec++;
            if ({up, dn, net_vote, no_trans, lock} !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc%0d: got %b want %b", i, {up, dn, net_vote, no_trans, lock}, exp_vec());
            end
            n_vec++;
            if (up === 1'b1 && dn === 1'b1) begin
                n_err++;
                $display("FAIL random_both cyc%0d: got up=1 dn=1 want at most one", i);
            end
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        test_reset();
        test_late();
        test_early();
        test_constant();
        test_quiet_lock();
        test_hysteresis();
        test_rst_mid();
        test_en_gap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
